// File: rtl/sign_narrow_pipe_pkg.sv
// Shared datapath definitions for 32->16 narrowing: default widths, saturation limits and
// the signed-fit test also used by the decode immediate checker.
package sign_narrow_pipe_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [OUT_W_DEF-1:0] SAT_POS = 16'h7FFF;
  localparam logic [OUT_W_DEF-1:0] SAT_NEG = 16'h8000;

  // True when value[IN_W_DEF-1:out_w-1] are all equal, i.e. the value survives a
  // round trip through an out_w-bit signed field.
  function automatic logic fits_signed(input logic [IN_W_DEF-1:0] value,
                                       input int unsigned out_w);
    logic fits;
    fits = 1'b1;
    for (int i = 0; i < int'(IN_W_DEF); i++) begin
      if ((i >= int'(out_w) - 1) && (value[i] != value[IN_W_DEF-1])) begin
        fits = 1'b0;
      end
    end
    return fits;
  endfunction

endpackage

// File: rtl/sign_narrow_pipe_stage_reg.sv
// Valid/data pipeline register: captures valid_i/data_i when load_i is high, otherwise holds.
module pipe_stage_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      // Bubbles leave the data untouched so an idle stage does not toggle.
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sign_narrow_pipe.sv
// Two-stage 32->16 signed narrowing unit with wrap/saturate selection, overflow flag and a
// saturating overflow event counter. Valid/ready on both sides.
module sign_narrow_pipe
  import sign_narrow_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,  // must not exceed IN_W_DEF
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  long,
  input  logic             sat_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] short,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned S1W = IN_W + 2;
  localparam int unsigned S2W = OUT_W + 1;

  localparam logic [OUT_W-1:0] SatPos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SatNeg = {1'b1, {(OUT_W-1){1'b0}}};

  logic             s1_valid, s2_valid;
  logic             s1_load, s2_load;
  logic [S1W-1:0]   s1_d, s1_q;
  logic [S2W-1:0]   s2_d, s2_q;
  logic [IN_W-1:0]  s1_long;
  logic             s1_sat, s1_fit, in_fit;
  logic [OUT_W-1:0] short_d;
  logic             ovf_d;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Sign-extending into the package width keeps the fit test exact for narrower inputs.
  assign in_fit = fits_signed(IN_W_DEF'($signed(long)), OUT_W);

  always_comb begin
    s2_load  = ~s2_valid | out_ready;
    in_ready = ~s1_valid | s2_load;
    s1_load  = in_ready;
    s1_d     = {long, sat_mode, in_fit};
  end

  pipe_stage_reg #(
    .W (S1W)
  ) u_s1 (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (s1_load),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_valid),
    .data_o  (s1_q)
  );

  always_comb begin
    {s1_long, s1_sat, s1_fit} = s1_q;
    ovf_d   = ~s1_fit;
    short_d = s1_long[OUT_W-1:0];
    if (!s1_fit && s1_sat) begin
      short_d = s1_long[IN_W-1] ? SatNeg : SatPos;
    end
    s2_d = {short_d, ovf_d};
  end

  pipe_stage_reg #(
    .W (S2W)
  ) u_s2 (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (s2_load),
    .valid_i (s1_valid),
    .data_i  (s2_d),
    .valid_o (s2_valid),
    .data_o  (s2_q)
  );

  assign out_valid    = s2_valid;
  assign {short, ovf} = s2_q;

  // Counts overflowing items as they enter S2; clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_load && s1_valid && !s1_fit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_cnt = cnt_q;

endmodule
